// File: rtl/pixel_unpacker.sv
// pixel_unpacker: AXI4-Stream receiver that unpacks 24-bit RGB pixels carried
// four-per-three 32-bit words and presents them one pixel per handshake,
// tagged with start-of-frame, end-of-line and end-of-frame markers.
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        valid,
    input  logic        ready,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        err
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] X_PENULT = XW'(X_SIZE - 2);
    localparam logic [YW-1:0] Y_LAST   = YW'(Y_SIZE - 1);

    // Word position inside a 3-word group; PH2B drains the second pixel of a PH2 word.
    typedef enum logic [1:0] {PH0, PH1, PH2, PH2B} phase_e;

    phase_e        r_state, w_state_nxt;
    logic [15:0]   r_carry, w_carry_nxt;
    logic [23:0]   r_hold,  w_hold_nxt;   // {r, g, b}
    logic [XW-1:0] r_x,     w_x_nxt;      // x of the next pixel to be produced
    logic [YW-1:0] r_y,     w_y_nxt;
    logic          r_valid, w_valid_nxt;
    logic [23:0]   r_pix,   w_pix_nxt;    // {r, g, b}
    logic          r_sof,   w_sof_nxt;
    logic          r_eol,   w_eol_nxt;
    logic          r_eof,   w_eof_nxt;
    logic          r_err,   w_err_nxt;

    logic          w_adv;
    logic          w_acc;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;

    phase_e        w_phase;
    logic [XW-1:0] w_xc;
    logic [YW-1:0] w_yc;
    logic          w_load;
    logic [23:0]   w_pix;
    logic          w_completes;
    logic          w_line_err;
    logic          w_eol;

    // The output stage can take a new pixel when empty or being drained this cycle.
    assign w_adv            = !r_valid || ready;
    assign in_stream_tready = aresetn && (r_state != PH2B) && w_adv;
    assign w_acc            = in_stream_tvalid && in_stream_tready;

    assign w_b0 = in_stream_tdata[7:0];
    assign w_b1 = in_stream_tdata[15:8];
    assign w_b2 = in_stream_tdata[23:16];
    assign w_b3 = in_stream_tdata[31:24];

    assign r     = r_pix[23:16];
    assign g     = r_pix[15:8];
    assign b     = r_pix[7:0];
    assign valid = r_valid;
    assign sof   = r_sof;
    assign eol   = r_eol;
    assign eof   = r_eof;
    assign err   = r_err;

    // Phase decode, pixel selection, position counters, markers and error detection.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        w_state_nxt = r_state;
        w_carry_nxt = r_carry;
        w_hold_nxt  = r_hold;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid && !ready;
        w_pix_nxt   = r_pix;
        w_sof_nxt   = r_sof;
        w_eol_nxt   = r_eol;
        w_eof_nxt   = r_eof;
        w_err_nxt   = 1'b0;
        w_phase     = r_state;
        w_xc        = r_x;
        w_yc        = r_y;
        w_load      = 1'b0;
        w_pix       = r_hold;
        w_completes = 1'b0;
        w_line_err  = 1'b0;
        w_eol       = 1'b0;

        if (w_acc) begin
            w_load = 1'b1;
            // Start of frame resynchronises phase and position before decoding.
            if (in_stream_tuser) begin
                w_phase = PH0;
                w_xc    = '0;
                w_yc    = '0;
            end
            case (w_phase)
                PH0: begin
                    w_pix       = {w_b2, w_b1, w_b0};
                    w_carry_nxt = {8'h00, w_b3};
                    w_state_nxt = PH1;
                    w_completes = (w_xc == X_LAST);
                end
                PH1: begin
                    w_pix       = {w_b1, w_b0, r_carry[7:0]};
                    w_carry_nxt = {w_b3, w_b2};
                    w_state_nxt = PH2;
                    w_completes = (w_xc == X_LAST);
                end
                default: begin
                    w_pix       = {w_b0, r_carry[15:8], r_carry[7:0]};
                    w_hold_nxt  = {w_b3, w_b2, w_b1};
                    w_state_nxt = PH2B;
                    w_completes = (w_xc == X_LAST) || (w_xc == X_PENULT);
                end
            endcase
            w_line_err = in_stream_tlast && !w_completes;
            w_err_nxt  = w_line_err
                       || (!in_stream_tlast && w_completes)
                       || (in_stream_tkeep != 4'hF);
        end else if ((r_state == PH2B) && w_adv) begin
            w_load      = 1'b1;
            w_pix       = r_hold;
            w_state_nxt = PH0;
        end

        if (w_load) begin
            w_eol       = (w_xc == X_LAST);
            w_valid_nxt = 1'b1;
            w_pix_nxt   = w_pix;
            w_sof_nxt   = w_acc && in_stream_tuser;
            w_eol_nxt   = w_eol;
            w_eof_nxt   = w_eol && (w_yc == Y_LAST);
            if (w_eol || w_line_err) begin
                w_x_nxt = '0;
                w_y_nxt = (w_yc == Y_LAST) ? '0 : w_yc + YW'(1);
            end else begin
                w_x_nxt = w_xc + XW'(1);
                w_y_nxt = w_yc;
            end
            // A premature tlast drops the partial group; the next word starts fresh.
            if (w_line_err) begin
                w_state_nxt = PH0;
                w_carry_nxt = '0;
            end
        end
    end

    // State, carry/hold storage, counters and output stage with synchronous reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= PH0;
            // NOTE: carry and hold are cleared too, so a mid-group reset cannot leak a stale pixel.
            r_carry <= '0;
            r_hold  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_pix   <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_carry <= w_carry_nxt;
            r_hold  <= w_hold_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
            r_pix   <= w_pix_nxt;
            r_sof   <= w_sof_nxt;
            r_eol   <= w_eol_nxt;
            r_eof   <= w_eof_nxt;
            r_err   <= w_err_nxt;
        end
    end

endmodule
